// File: rtl/seq_pkg.sv
// Shared types and default pattern constants for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT} tx_state_t;

  localparam int unsigned PAT_W_DEF = 4;
  localparam logic [3:0]  PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Parallel word handshake into the serializer.
interface seq_pattern_tx_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/seq_pattern_ref.sv
// Reference model of a registered-output overlapping pattern detector plus a
// saturating match counter; usable standalone as a scoreboard model.
module seq_pattern_ref
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_i,
  output logic             expect_detect_o,
  output logic [CNT_W-1:0] match_count_o
);

  localparam int unsigned     FillW   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              det_q;
  logic [PAT_W-1:0]  window;
  logic              hit;

  // Oldest bit sits in the MSB, matching the pattern's bit order.
  assign window = {hist_q, bit_i};
  assign hit    = (fill_q == FillMax) && (window == PATTERN);

  always_comb begin
    hist_d = window[PAT_W-2:0];
    fill_d = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
    cnt_d  = cnt_q;
    if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      det_q  <= hit;
    end
  end

  assign expect_detect_o = det_q;
  assign match_count_o   = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// MSB-first word serializer with a built-in reference pattern tracker on the
// emitted line, for driving and scoring a sequence detector.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned      WORD_W  = 8,
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  word_if,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             expect_detect,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  localparam int unsigned         BitCntW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BitCntW-1:0]  LastBit = BitCntW'(WORD_W - 1);

  tx_state_t          state_q;
  logic [WORD_W-1:0]  shift_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic               seq_out_q;
  logic               seq_valid_q;
  logic               ready;
  logic               accept;

  // Ready on the last bit lets a queued word follow with no idle bubble.
  assign ready  = (state_q == IDLE) || ((state_q == SHIFT) && (bit_cnt_q == LastBit));
  assign accept = word_if.word_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
    end else if (accept) begin
      state_q     <= SHIFT;
      shift_q     <= {word_if.word_in[WORD_W-2:0], 1'b0};
      bit_cnt_q   <= '0;
      seq_out_q   <= word_if.word_in[WORD_W-1];
      seq_valid_q <= 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_cnt_q != LastBit) begin
            shift_q     <= {shift_q[WORD_W-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q + BitCntW'(1);
            seq_out_q   <= shift_q[WORD_W-1];
            seq_valid_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          seq_out_q   <= 1'b0;
          seq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_if.word_ready = ready;
  assign seq_out            = seq_out_q;
  assign seq_valid          = seq_valid_q;
  assign busy               = (state_q == SHIFT);

  // Tracker watches the line itself, idle zeros included.
  seq_pattern_ref #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_ref (
    .clk             (clk),
    .reset           (reset),
    .bit_i           (seq_out_q),
    .expect_detect_o (expect_detect),
    .match_count_o   (match_count)
  );

  a_idle_low: assert property (@(posedge clk) disable iff (reset) !seq_valid |-> !seq_out);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle line checks against hand-built
// masks, plus a narrow-counter instance for saturation.
module tb_seq_pattern_tx;

  logic        clk;
  logic        reset;
  logic        seq_out, seq_valid, expect_detect, busy;
  logic [15:0] match_count;
  logic        s_seq_out, s_seq_valid, s_expect_detect, s_busy;
  logic [1:0]  s_match_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  seq_pattern_tx_if #(.WORD_W(8)) mif ();
  seq_pattern_tx_if #(.WORD_W(8)) sif ();

  seq_pattern_tx #(.WORD_W(8), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(16)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .word_if       (mif),
    .seq_out       (seq_out),
    .seq_valid     (seq_valid),
    .expect_detect (expect_detect),
    .match_count   (match_count),
    .busy          (busy)
  );

  seq_pattern_tx #(.WORD_W(8), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .clk           (clk),
    .reset         (reset),
    .word_if       (sif),
    .seq_out       (s_seq_out),
    .seq_valid     (s_seq_valid),
    .expect_detect (s_expect_detect),
    .match_count   (s_match_count),
    .busy          (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " seq_out"}, seq_out, 0);
    check_eq({tag, " seq_valid"}, seq_valid, 0);
    check_eq({tag, " expect"}, expect_detect, 0);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " count"}, match_count, 0);
    check_eq({tag, " ready"}, mif.word_ready, 1);
  endtask

  // Called just after a negedge. Cycle k is the k-th cycle after the accepting
  // edge; masks give the required value of each output in that cycle (bit k).
  task automatic watch(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                       input bit two, input int ncyc, input logic [31:0] dmask,
                       input logic [31:0] vmask, input logic [31:0] pmask,
                       input logic [31:0] rmask);
    mif.word_in    = w0;
    mif.word_valid = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (two) mif.word_in = w1;
        else     mif.word_valid = 1'b0;
      end
      if (k == 9) mif.word_valid = 1'b0;
      check_eq($sformatf("%s c%0d seq_out", tag, k), seq_out, dmask[k]);
      check_eq($sformatf("%s c%0d seq_valid", tag, k), seq_valid, vmask[k]);
      check_eq($sformatf("%s c%0d busy", tag, k), busy, vmask[k]);
      check_eq($sformatf("%s c%0d expect", tag, k), expect_detect, pmask[k]);
      check_eq($sformatf("%s c%0d ready", tag, k), mif.word_ready, rmask[k]);
    end
  endtask

  initial begin
    reset          = 1'b1;
    mif.word_in    = '0;
    mif.word_valid = 1'b0;
    sif.word_in    = '0;
    sif.word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("por");

    // B6 = 10110110: matches end on bits 4 and 7 -> pulses in cycles 5 and 8.
    apply_reset();
    check_idle("rst");
    watch("b6", 8'hB6, 8'h00, 1'b0, 10, 32'h0DA, 32'h1FE, 32'h120, 32'h700);
    check_eq("b6 count", match_count, 2);

    // 05 then B0: matches end on stream bits 9 and 12 (shared bit 9).
    apply_reset();
    watch("x05b0", 8'h05, 8'hB0, 1'b1, 18, 32'h1B40, 32'h1FFFE, 32'h2400, 32'h70100);
    check_eq("x05b0 count", match_count, 2);

    // 01, three idle cycles, C0: line never carries 1011.
    apply_reset();
    watch("gap01", 8'h01, 8'h00, 1'b0, 11, 32'h100, 32'h1FE, 32'h0, 32'hF00);
    watch("gapc0", 8'hC0, 8'h00, 1'b0, 10, 32'h006, 32'h1FE, 32'h0, 32'h700);
    check_eq("gap count", match_count, 0);

    // BB BB back to back, valid held: four matches, ready only on bits 8 and 16.
    apply_reset();
    watch("bbbb", 8'hBB, 8'hBB, 1'b1, 18, 32'h1BBBA, 32'h1FFFE, 32'h22220, 32'h70100);
    check_eq("bbbb count", match_count, 4);

    // Reset after bit 3 of BB; bit 4 would otherwise complete 1011.
    mif.word_in    = 8'hBB;
    mif.word_valid = 1'b1;
    @(negedge clk);
    mif.word_valid = 1'b0;
    check_eq("mid c1 seq_out", seq_out, 1);
    repeat (2) @(negedge clk);
    check_eq("mid c3 seq_out", seq_out, 1);
    check_eq("mid c3 count", match_count, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid post");
    for (int k = 5; k <= 12; k++) begin
      @(negedge clk);
      check_eq($sformatf("mid c%0d expect", k), expect_detect, 0);
      check_eq($sformatf("mid c%0d seq_valid", k), seq_valid, 0);
    end
    check_eq("mid end count", match_count, 0);

    // Two-bit counter: three BB words give six pulses, count pinned at 3.
    pulses         = 0;
    sif.word_in    = 8'hBB;
    sif.word_valid = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k == 17) sif.word_valid = 1'b0;
      if (s_expect_detect) pulses++;
      if (k == 15) check_eq("sat c15 count", s_match_count, 3);
    end
    check_eq("sat pulses", pulses, 6);
    check_eq("sat count", s_match_count, 3);
    check_eq("sat idle", s_seq_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
